alu_div_16: RTL and testbench



---
 rtl/alu_div_pkg.sv | 16 +
 rtl/cla_16.sv | 32 +++
 rtl/alu_div_16.sv | 146 ++++++++++++++
 tb/tb_alu_div_16.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package alu_div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

    // Two's-complement magnitude; -32768 maps to 16'h8000 and is used as unsigned 32768.
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] x,
                                                     input logic sgn);
        return (sgn && x[DIV_WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder/subtractor: 4-bit lookahead groups, group carries chained.
module cla_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] bx, g, p;
    logic [16:0] c;

    assign bx   = b ^ {16{sub}};
    assign g    = a & bx;
    assign p    = a ^ bx;
    assign c[0] = sub;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign sum  = p ^ c[15:0];
    assign cout = c[16];

endmodule

// File: rtl/alu_div_16.sv
// Iterative 16-bit restoring divider (unsigned / two's-complement), one quotient bit per cycle.
// Optional build macro DIV_EARLY_EXIT_EN skips iteration when |dividend| < |divisor|.
module alu_div_16
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t state_q, state_d;

    logic [WIDTH-1:0]     q_sh_q, q_sh_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     remo_q, remo_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH-1:0] mag_a, mag_b, trial;
    logic             no_borrow, nonneg;

    assign mag_a = div_mag(dividend, signed_op);
    assign mag_b = div_mag(divisor, signed_op);

    // The remainder never reaches the divisor, so the 17th bit of the shifted
    // partial remainder is just rem_q's MSB; the adder handles the low 16 bits.
    cla_16 u_trial (
        .a   ({rem_q[WIDTH-2:0], q_sh_q[WIDTH-1]}),
        .b   (dvs_q),
        .sub (1'b1),
        .sum (trial),
        .cout(no_borrow)
    );

    assign nonneg = rem_q[WIDTH-1] | no_borrow;

    always_comb begin
        state_d = state_q;
        q_sh_d  = q_sh_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    qneg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d = signed_op & dividend[WIDTH-1];
                    dvs_d  = mag_b;
                    rem_d  = '0;
                    q_sh_d = mag_a;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    // Divide-by-zero results are staged so FIX passes them through unchanged.
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        q_sh_d  = DIV_ZERO_QUOT;
                        rem_d   = dividend;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIX;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (mag_a < mag_b) begin
                        q_sh_d  = '0;
                        rem_d   = mag_a;
                        state_d = FIX;
                    end
`endif
                    else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                q_sh_d = {q_sh_q[WIDTH-2:0], nonneg};
                rem_d  = nonneg ? trial : {rem_q[WIDTH-2:0], q_sh_q[WIDTH-1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == DIV_CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                quot_d  = qneg_q ? -q_sh_q : q_sh_q;
                remo_d  = rneg_q ? -rem_q : rem_q;
                dbz_d   = dz_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_sh_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_sh_q  <= q_sh_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_16.sv
// Self-checking bench for alu_div_16: vector table, handshake corner cases, random ops vs. arithmetic model.
module tb_alu_div_16;

    logic        clk, rst, start, signed_op;
    logic [15:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam int EE_LAT = EE ? 2 : 18;

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    alu_div_16 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: plain integer division (truncates toward zero, remainder follows dividend).
    task automatic ref_div(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic dz, output int lat);
        int na, nb, nq, nr;
        if (b == 16'd0) begin
            q = 16'hFFFF; r = a; dz = 1'b1; lat = 2;
        end else begin
            na = sgn ? int'($signed(a)) : int'(a);
            nb = sgn ? int'($signed(b)) : int'(b);
            nq = na / nb;
            nr = na % nb;
            q  = 16'(nq);
            r  = 16'(nr);
            dz = 1'b0;
            lat = (EE && ((na < 0 ? -na : na) < (nb < 0 ? -nb : nb))) ? 2 : 18;
        end
    endtask

    // Issue one op and wait for done; reports results, latency and handshake sanity.
    task automatic run_op(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r, output logic dz,
                          output int lat, output logic seen, output logic busy_bad,
                          output logic busy_at_done, output logic done_after);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; signed_op = sgn; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_bad = 1'b0;
        while (!done && cyc < 40) begin
            if (!busy) busy_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        seen = done;
        q = quotient; r = remainder; dz = div_by_zero;
        lat = cyc;
        busy_at_done = busy;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic check_op(input string tag, input logic sgn, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] eq, input logic [15:0] er,
                            input logic edz, input int elat);
        logic [15:0] q, r;
        logic dz, seen, bb, bd, da;
        int lat;
        run_op(sgn, a, b, q, r, dz, lat, seen, bb, bd, da);
        chk({tag, ".done_seen"}, seen, 1'b1);
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".quotient"}, q, eq);
        chk({tag, ".remainder"}, r, er);
        chk({tag, ".div_by_zero"}, dz, edz);
        chk({tag, ".busy_while_running"}, bb, 1'b0);
        chk({tag, ".busy_at_done"}, bd, 1'b0);
        chk({tag, ".done_one_cycle"}, da, 1'b0);
    endtask

    task automatic expect_no_done(input string tag, input int ncyc);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        chk({tag, ".no_done"}, saw, 1'b0);
    endtask

    initial begin
        logic [15:0] a, b, eq, er;
        logic        sgn, edz;
        int          elat, cyc;
        logic        saw;

        tbl[0]  = '{1'b0, 16'd100,   16'd7,    16'd14,   16'd2,    1'b0, 18};
        tbl[1]  = '{1'b1, 16'hFF9C,  16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 18};
        tbl[2]  = '{1'b1, 16'd100,   16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 18};
        tbl[3]  = '{1'b0, 16'd1234,  16'd0,    16'hFFFF, 16'd1234, 1'b1, 2};
        tbl[4]  = '{1'b1, 16'h8000,  16'hFFFF, 16'h8000, 16'd0,    1'b0, 18};
        tbl[5]  = '{1'b0, 16'hFFFF,  16'd1,    16'hFFFF, 16'd0,    1'b0, 18};
        tbl[6]  = '{1'b0, 16'd3,     16'd10,   16'd0,    16'd3,    1'b0, EE_LAT};
        tbl[7]  = '{1'b1, 16'hFFFD,  16'd10,   16'd0,    16'hFFFD, 1'b0, EE_LAT};
        tbl[8]  = '{1'b1, 16'hFFFF,  16'd0,    16'hFFFF, 16'hFFFF, 1'b1, 2};
        tbl[9]  = '{1'b0, 16'd7,     16'd7,    16'd1,    16'd0,    1'b0, 18};
        tbl[10] = '{1'b0, 16'hFFFF,  16'hFFFF, 16'd1,    16'd0,    1'b0, 18};
        tbl[11] = '{1'b1, 16'h8000,  16'h8000, 16'd1,    16'd0,    1'b0, 18};
        tbl[12] = '{1'b0, 16'd0,     16'd5,    16'd0,    16'd0,    1'b0, EE_LAT};

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.quotient", quotient, 16'd0);
        chk("reset.remainder", remainder, 16'd0);
        chk("reset.div_by_zero", div_by_zero, 1'b0);

        for (int i = 0; i < 13; i++)
            check_op($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                     tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat);

        // start while busy is ignored and not queued
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 16'd100; divisor = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; dividend = 16'd5; divisor = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 6;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_start.done_seen", done, 1'b1);
        chk("busy_start.latency", cyc, 18);
        chk("busy_start.quotient", quotient, 16'd14);
        chk("busy_start.remainder", remainder, 16'd2);
        expect_no_done("busy_start", 25);

        // reset in the middle of iteration abandons the op
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 16'd1000; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.done", done, 1'b0);
        chk("midrst.quotient", quotient, 16'd0);
        chk("midrst.remainder", remainder, 16'd0);
        chk("midrst.div_by_zero", div_by_zero, 1'b0);
        expect_no_done("midrst", 25);

        // start coinciding with reset loses to reset
        check_op("pre_rst_start", 1'b0, 16'd50, 16'd0, 16'hFFFF, 16'd50, 1'b1, 2);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; dividend = 16'd9; divisor = 16'd2;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_start.busy", busy, 1'b0);
        chk("rst_start.div_by_zero", div_by_zero, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        chk("rst_start.no_activity", saw, 1'b0);

        for (int n = 0; n < 300; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(1, 15));
                1:       b = 16'($urandom_range(1, 255)) | (sgn ? 16'hFF00 : 16'h0000);
                default: b = 16'($urandom);
            endcase
            if (b == 16'd0) b = 16'd1;
            ref_div(sgn, a, b, eq, er, edz, elat);
            check_op($sformatf("rand%0d", n), sgn, a, b, eq, er, edz, elat);
        end

        for (int n = 0; n < 6; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            ref_div(sgn, a, 16'd0, eq, er, edz, elat);
            check_op($sformatf("dbz%0d", n), sgn, a, 16'd0, eq, er, edz, elat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
